dcache_tag_ram: RTL and testbench

- Simple dual-port RAM holding data-cache tag entries: one write port, one read port, independent clocks.
- Default geometry is 512 entries x 21 bits; the tag pipeline writes on refill and reads on lookup.
- Read data is registered, with 1-cycle latency from rd_addr to rd_data.
- Sits beside the dcache data array. A global-reset primitive (GTP_GRS, GRS_N tied high) exists at top level and is outside this block.

---
 rtl/dcache_tag_ram.sv | 65 ++++++
 tb/tb_dcache_tag_ram.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/dcache_tag_ram.sv
// dcache_tag_ram: simple dual-port tag RAM for the data cache.
//   One write port (wr_clk domain) and one read port (rd_clk domain). The
//   two clocks are independent. Read data is registered. OUTPUT_REG adds a
//   second output stage, so read latency is 1 or 2 rd_clk edges.
//
// Ports:
//   wr_clk, tb_wr_rst    write clock; active-high reset that only blocks writes
//   rd_clk, rd_rst       read clock; async active-high reset that clears rd_data
//   wr_en, wr_addr, wr_data   write strobe, address and word
//   rd_addr              read address; a read is taken on every rd_clk edge
//   rd_data              registered read data
//
// Neither reset clears the memory contents.

module dcache_tag_ram #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 21,
    parameter int OUTPUT_REG = 0
) (
    input  logic                  wr_clk,
    input  logic                  tb_wr_rst,
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] rd_q;

    // The storage has no reset. The write reset only gates the strobe, so
    // writes that land while it is asserted are dropped. Earlier contents
    // are preserved.
    always_ff @(posedge wr_clk) begin
        if (wr_en && !tb_wr_rst)
            mem[wr_addr] <= wr_data;
    end

    // The read samples the array before this edge's write commits. On a
    // shared clock, a same-address collision therefore returns the old
    // word (read-first).
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) rd_q <= '0;
        else        rd_q <= mem[rd_addr];
    end

    generate
        if (OUTPUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] rd_q2;
            always_ff @(posedge rd_clk or posedge rd_rst) begin
                if (rd_rst) rd_q2 <= '0;
                else        rd_q2 <= rd_q;
            end
            assign rd_data = rd_q2;
        end else begin : g_noreg
            assign rd_data = rd_q;
        end
    endgenerate

endmodule

// File: tb/tb_dcache_tag_ram.sv
// tb_dcache_tag_ram: scoreboard bench for dcache_tag_ram.
// Two instances share one clock and the same stimulus: OUTPUT_REG=0 and
// OUTPUT_REG=1. The reference model is a plain array plus a "known" flag
// per word. Each read issued pushes its expected word, tagged with the edge
// after which it must be visible. A negedge monitor pops and compares.

module tb_dcache_tag_ram;

    localparam int AW    = 9;
    localparam int DW    = 21;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        int          due;
        logic [DW-1:0] exp;
    } exp_t;

    logic          clk = 1'b0;
    logic          tb_wr_rst = 1'b1;
    logic          rd_rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data0, rd_data1;

    int errors = 0;
    int checks = 0;
    int edge_cnt = 0;

    exp_t q0[$];
    exp_t q1[$];

    logic [DW-1:0] model [DEPTH];
    bit            known [DEPTH];

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    dcache_tag_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTPUT_REG(0)) dut0 (
        .wr_clk(clk), .tb_wr_rst(tb_wr_rst), .rd_clk(clk), .rd_rst(rd_rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data0)
    );

    dcache_tag_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTPUT_REG(1)) dut1 (
        .wr_clk(clk), .tb_wr_rst(tb_wr_rst), .rd_clk(clk), .rd_rst(rd_rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data1)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @edge %0d: got %h expected %h", name, edge_cnt, act, exp);
        end
    endtask

    // Monitor: checks every expectation that falls due on this edge.
    always @(negedge clk) begin
        exp_t e;
        while (q0.size() != 0 && q0[0].due <= edge_cnt) begin
            e = q0.pop_front();
            chk("rd_data lat1", rd_data0, e.exp);
        end
        while (q1.size() != 0 && q1[0].due <= edge_cnt) begin
            e = q1.pop_front();
            chk("rd_data lat2", rd_data1, e.exp);
        end
    end

    // One clock of stimulus. Expectations are taken from the model before
    // this cycle's write is applied, which gives read-first collisions.
    // A read issued while rd_rst is held must come back as 0.
    task automatic step(input bit wrst, input bit rrst, input bit we,
                        input int wa, input logic [DW-1:0] wd, input int ra);
        exp_t e;
        @(posedge clk);
        #1;
        tb_wr_rst = wrst;
        rd_rst    = rrst;
        wr_en     = we;
        wr_addr   = AW'(wa);
        wr_data   = wd;
        rd_addr   = AW'(ra);
        if (rrst) begin
            e.exp = '0;
            e.due = edge_cnt + 1; q0.push_back(e);
            e.due = edge_cnt + 2; q1.push_back(e);
        end else if (known[ra % DEPTH]) begin
            e.exp = model[ra % DEPTH];
            e.due = edge_cnt + 1; q0.push_back(e);
            e.due = edge_cnt + 2; q1.push_back(e);
        end
        if (we && !wrst) begin
            model[wa % DEPTH] = wd;
            known[wa % DEPTH] = 1'b1;
        end
    endtask

    // Raises rd_rst between clock edges and checks that both outputs clear
    // immediately. In-flight expectations are dropped, because the pipeline
    // registers they depended on were just cleared.
    task automatic async_rd_reset();
        @(posedge clk);
        #3;
        rd_rst = 1'b1;
        #1;
        chk("async rd_rst lat1", rd_data0, '0);
        chk("async rd_rst lat2", rd_data1, '0);
        q0.delete();
        q1.delete();
    endtask

    initial begin
        logic [DW-1:0] d;
        int ra;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

        // Both resets held for 200 ns while writes are attempted.
        // These writes must not land, so the model ignores them.
        for (int i = 0; i < 20; i++)
            step(1, 1, i[0], $urandom_range(0, DEPTH-1), DW'($urandom), $urandom_range(0, DEPTH-1));

        // Full fill: addresses 1..511, then 0. Data starts at 0x1FFFFF and
        // decrements by 1 per write. Reads of still-unknown words go unchecked.
        d = 21'h1FFFFF;
        for (int i = 1; i <= DEPTH; i++) begin
            step(0, 0, 1, i % DEPTH, d, $urandom_range(0, DEPTH-1));
            d = d - 1'b1;
        end

        // Full readback in the same order, one address per edge.
        for (int i = 1; i <= DEPTH; i++)
            step(0, 0, 0, 0, '0, i % DEPTH);

        // Read-first collision at address 5. The old word (0x1FFFFB) comes
        // back first, then 0x00ABC.
        step(0, 0, 1, 5, 21'h00ABC, 5);
        step(0, 0, 0, 0, '0, 5);

        // Mid-burst write reset: writes to 100..109, with tb_wr_rst high on
        // two of them. Readback must show old data only at those two.
        for (int i = 0; i < 10; i++)
            step((i == 4 || i == 5), 0, 1, 100 + i, DW'($urandom), $urandom_range(0, DEPTH-1));
        for (int i = 0; i < 10; i++)
            step(0, 0, 0, 0, '0, 100 + i);

        // Read burst, async read reset for three cycles, then more reads.
        // Memory contents must survive the reset.
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, '0, $urandom_range(0, DEPTH-1));
        async_rd_reset();
        step(0, 1, 0, 0, '0, $urandom_range(0, DEPTH-1));
        step(0, 1, 0, 0, '0, $urandom_range(0, DEPTH-1));
        for (int i = 0; i < 40; i++) step(0, 0, 0, 0, '0, $urandom_range(0, DEPTH-1));

        // Random traffic on a small address window. This forces frequent
        // collisions and occasional write-reset cycles. An async read reset
        // is dropped into the middle.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                async_rd_reset();
                step(0, 1, 0, 0, '0, 0);
            end
            ra = $urandom_range(0, 15);
            step(($urandom_range(0, 19) == 0), 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 15), DW'($urandom), ra);
        end

        // Drain: outstanding expectations must be consumed within a few edges.
        step(0, 0, 0, 0, '0, 0);
        for (int i = 0; i < 10 && (q0.size() != 0 || q1.size() != 0); i++)
            @(posedge clk);
        @(negedge clk);
        #1;
        if (q0.size() != 0 || q1.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d/%0d expectations left, required 0", q0.size(), q1.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
